nucore_hex_pager: RTL

//   Display-side consumer of the NuCore 32-bit result bus. It captures each valid result and

---
 rtl/nucore_pkg.sv | 37 +++
 rtl/hex_to_7seg.sv | 11 +
 rtl/nucore_hex_pager.sv | 112 +++++++++++
 3 files changed

// File: rtl/nucore_pkg.sv
// rtl/nucore_pkg.sv - shared segment codes, page-state encoding and nibble decode
package nucore_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_H     = 7'b1001000;

  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,
    ST_PAGE_LO = 2'd1,
    ST_PAGE_HI = 2'd2
  } page_state_t;

  // Segment order a..g with a at index 0; a 0 lights the segment.
  function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
    logic [0:6] seg;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational nibble to active-low 7-segment decode
module hex_to_7seg
  import nucore_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/nucore_hex_pager.sv
// rtl/nucore_hex_pager.sv - captures the NuCore result bus and pages it across six hex digits
module nucore_hex_pager
  import nucore_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int TIMER_W      = 26
) (
  input  logic [1:0]  KEY,
  input  logic [31:0] result,
  input  logic        result_valid,
  input  logic        hold,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3,
  output logic [0:6]  HEX4,
  output logic [0:6]  HEX5,
  output logic [0:0]  LEDR
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DWELL_CYCLES - 1);

  logic clk;
  logic rst_n;
  assign clk   = KEY[0];
  assign rst_n = KEY[1];

  page_state_t        state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [31:0]        shown_val;
  logic [0:6]         digit [8];
  logic [0:6]         hex_nxt [6];
  logic               led_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      hex_to_7seg u_dec (
        .nibble (shown_val[4*gi +: 4]),
        .seg    (digit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BLANK;
      timer     <= '0;
      shown_val <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (result_valid) shown_val <= result;
    end
  end

  // A capture outranks both hold and dwell expiry and always restarts on the low page.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (result_valid) begin
      state_nxt = ST_PAGE_LO;
      timer_nxt = '0;
    end else if (state != ST_BLANK && !hold) begin
      if (timer == TIMER_LAST) begin
        timer_nxt = '0;
        state_nxt = (state == ST_PAGE_LO) ? ST_PAGE_HI : ST_PAGE_LO;
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) hex_nxt[i] = SEG_BLANK;
    led_nxt = 1'b0;
    case (state)
      ST_PAGE_LO: begin
        for (int i = 0; i < 6; i++) hex_nxt[i] = digit[i];
      end
      ST_PAGE_HI: begin
        hex_nxt[0] = digit[6];
        hex_nxt[1] = digit[7];
        hex_nxt[2] = SEG_H;
        led_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Pins are driven from flops, so the display trails the internal state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
      LEDR <= 1'b0;
    end else begin
      HEX0 <= hex_nxt[0];
      HEX1 <= hex_nxt[1];
      HEX2 <= hex_nxt[2];
      HEX3 <= hex_nxt[3];
      HEX4 <= hex_nxt[4];
      HEX5 <= hex_nxt[5];
      LEDR <= led_nxt;
    end
  end

endmodule
